data_ram_sync: RTL and testbench
================================

Name: data_ram_sync

Overview:
- Synchronous, parametrised successor of the byte-addressed big-endian 256x8 data RAM.
- Serves the MEM stage of the pipeline through a valid/ready request port and a registered response port.
- Access modes: byte, halfword, word and a real two-beat doubleword (read and write), with optional sign-extended loads.
- Detects misaligned and out-of-range accesses and reports them as errors instead of printing a message.

Parameters:
- DEPTH, 256: memory size in bytes; power of two, at least 8.
- ADDR_W, 32: width of the address port.
- SIGN_EXT_EN, 1: when 0, the signed_ld input is ignored and loads are always zero-extended.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request (or second write beat) present.
- req_ready  out  1  request accepted on a cycle with req_valid && req_ready.
- rw  in  1  0 = read, 1 = write.
- mode  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- signed_ld  in  1  sign-extend byte/halfword reads.
- addr  in  ADDR_W  byte address of the most significant byte (big-endian).
- wdata  in  32  write data; right-aligned for byte and halfword.
- rsp_valid  out  1  one-cycle pulse per response beat.
- rdata  out  32  read data; 0 for write acks and errors.
- rsp_last  out  1  final beat of the transaction.
- err  out  1  valid with rsp_valid; access rejected.

Behaviour:
- Reset (synchronous, active-high): state IDLE; rsp_valid, rsp_last, err = 0; rdata = 0. Memory contents are not cleared.
- States:
  - IDLE: req_ready = 1.
  - DW_RD2: req_ready = 0.
  - DW_WR2: req_ready = 1; accepts only the second data beat.
- Latency: the response is registered and appears exactly 1 cycle after acceptance. No back-pressure on the response port.
- Byte order: big-endian. Byte at addr is the MSB of the accessed unit (halfword, word or doubleword).
- Byte/halfword reads: zero-extended, or sign-extended when signed_ld && SIGN_EXT_EN.
- Error checks, applied at acceptance in IDLE:
  - Misalignment: halfword needs addr[0] = 0; word needs addr[1:0] = 0; doubleword needs addr[2:0] = 0.
  - Range: addr + size > DEPTH (computed without overflow, using full ADDR_W) is an error.
  - On error: no memory write, single beat with err = 1, rsp_last = 1, rdata = 0; state stays IDLE.
- Single reads/writes (byte, halfword, word):
  - Write updates memory at the accepting edge.
  - Response has rdata = 0 for writes, rsp_last = 1.
- Doubleword read:
  - Acceptance in IDLE moves to DW_RD2.
  - Beat 1 (cycle +1): Mem[a..a+3], rsp_last = 0.
  - Beat 2 (cycle +2): Mem[a+4..a+7], rsp_last = 1. Then IDLE.
  - The address is latched at acceptance, so addr may change during DW_RD2.
- Doubleword write:
  - Acceptance in IDLE writes wdata (high word) to a..a+3, moves to DW_WR2, and acks with rsp_last = 0.
  - In DW_WR2, the next req_valid writes wdata (low word) to a+4..a+7, acks with rsp_last = 1, returns to IDLE.
  - rw, mode and addr are ignored in DW_WR2. The state waits indefinitely for that beat.
- Reset mid-doubleword: returns to IDLE immediately and any pending beat is dropped. The high word of an interrupted write stays written.
- Single port: read-during-write cannot occur. A read following a write to the same address returns the new data.

Decomposition:
- Package data_ram_pkg:
  - mode encodings MODE_BYTE, MODE_HALF, MODE_WORD, MODE_DWORD;
  - state enum IDLE, DW_RD2, DW_WR2;
  - function size_of(mode) returning 1/2/4/8.
- One sub-module, data_ram_access_chk: combinational alignment and range checker, outputs err_misalign and err_range.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10 -> rdata 0xDEADBEEF one cycle after acceptance, rsp_last 1; byte read @0x11 -> 0x000000AD.
- Halfword write 0x80F0 @0x20; halfword read @0x20 with signed_ld=1 -> 0xFFFF80F0, signed_ld=0 -> 0x000080F0; byte read @0x21 signed -> 0xFFFFFFF0.
- Doubleword write 0x11223344 then 0x55667788 @0x40 (second beat 3 idle cycles later); doubleword read @0x40 -> beats 0x11223344 (last 0) then 0x55667788 (last 1), req_ready 0 during the second beat.
- Word read @0x02, halfword write @0x05, doubleword @0x04 -> each gives err 1, rsp_last 1, rdata 0, and memory is unchanged.
- Word access @DEPTH-4 = 252 succeeds; word @256 and doubleword @DEPTH-8+8 -> err 1.
- Reset asserted in DW_WR2 after high word 0xAAAAAAAA @0x80 -> state IDLE, outputs 0; later doubleword read @0x80 returns 0xAAAAAAAA then the old contents of 0x84..0x87.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the synchronous big-endian data RAM.
package data_ram_pkg;

   localparam logic [1:0] MODE_BYTE  = 2'b00;
   localparam logic [1:0] MODE_HALF  = 2'b01;
   localparam logic [1:0] MODE_WORD  = 2'b10;
   localparam logic [1:0] MODE_DWORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DW_RD2 = 2'd1,
      DW_WR2 = 2'd2
   } state_e;

   function automatic logic [3:0] size_of(input logic [1:0] mode);
      case (mode)
         MODE_BYTE: return 4'd1;
         MODE_HALF: return 4'd2;
         MODE_WORD: return 4'd4;
         default:   return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/data_ram_access_chk.sv
// Combinational alignment and range check for one access at its first byte address.
module data_ram_access_chk
   import data_ram_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        mode,
   output logic              err_misalign,
   output logic              err_range
);

   logic [3:0]      sz;
   logic [ADDR_W:0] end_addr;

   // One extra bit keeps addresses near the top of the address space from wrapping.
   always_comb begin
      sz        = size_of(mode);
      end_addr  = {1'b0, addr} + {{(ADDR_W-3){1'b0}}, sz};
      err_range = end_addr > (ADDR_W+1)'(DEPTH);
   end

   always_comb begin
      case (mode)
         MODE_HALF:  err_misalign = addr[0];
         MODE_WORD:  err_misalign = |addr[1:0];
         MODE_DWORD: err_misalign = |addr[2:0];
         default:    err_misalign = 1'b0;
      endcase
   end

endmodule

// File: rtl/data_ram_sync.sv
// Byte-addressed big-endian data RAM with valid/ready requests, registered responses
// and two-beat doubleword transfers.
module data_ram_sync
   import data_ram_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 32,
   parameter bit SIGN_EXT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              rw,
   input  logic [1:0]        mode,
   input  logic              signed_ld,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              rsp_valid,
   output logic [31:0]       rdata,
   output logic              rsp_last,
   output logic              err
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rsp_last_q, rsp_last_d;
   logic          err_q, err_d;

   logic          err_misalign, err_range;
   logic [AW-1:0] acc_idx, rd_idx, wr_idx;
   logic [31:0]   rd_word, load_val, wr_lj;
   logic [2:0]    wr_n;
   logic          wr_en, sext;

   data_ram_access_chk #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_chk (
      .addr         (addr),
      .mode         (mode),
      .err_misalign (err_misalign),
      .err_range    (err_range)
   );

   assign acc_idx = addr[AW-1:0];
   assign rd_idx  = (state_q == DW_RD2) ? addr_q + AW'(4) : acc_idx;
   assign rd_word = {mem_q[rd_idx], mem_q[rd_idx + AW'(1)],
                     mem_q[rd_idx + AW'(2)], mem_q[rd_idx + AW'(3)]};
   assign sext    = signed_ld && SIGN_EXT_EN;

   // Loads read the unit left-justified, so its MSB byte sits in rd_word[31:24].
   always_comb begin
      case (mode)
         MODE_BYTE: load_val = {{24{sext & rd_word[31]}}, rd_word[31:24]};
         MODE_HALF: load_val = {{16{sext & rd_word[31]}}, rd_word[31:16]};
         default:   load_val = rd_word;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rsp_valid_d = 1'b0;
      rdata_d     = '0;
      rsp_last_d  = 1'b0;
      err_d       = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = acc_idx;
      wr_n        = 3'd4;
      wr_lj       = wdata;
      req_ready   = (state_q != DW_RD2);
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               rsp_valid_d = 1'b1;
               if (err_misalign || err_range) begin
                  err_d      = 1'b1;
                  rsp_last_d = 1'b1;
               end else if (mode == MODE_DWORD) begin
                  addr_d = acc_idx;
                  if (rw) begin
                     wr_en   = 1'b1;
                     state_d = DW_WR2;
                  end else begin
                     rdata_d = rd_word;
                     state_d = DW_RD2;
                  end
               end else begin
                  rsp_last_d = 1'b1;
                  if (rw) begin
                     wr_en = 1'b1;
                     case (mode)
                        MODE_BYTE: begin wr_n = 3'd1; wr_lj = {wdata[7:0], 24'h0}; end
                        MODE_HALF: begin wr_n = 3'd2; wr_lj = {wdata[15:0], 16'h0}; end
                        default:   begin wr_n = 3'd4; wr_lj = wdata; end
                     endcase
                  end else begin
                     rdata_d = load_val;
                  end
               end
            end
         end
         DW_RD2: begin
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
            rdata_d     = rd_word;
            state_d     = IDLE;
         end
         DW_WR2: begin
            if (req_valid) begin
               wr_en       = 1'b1;
               wr_idx      = addr_q + AW'(4);
               rsp_valid_d = 1'b1;
               rsp_last_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Storage is never cleared; a write racing reset is dropped.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (3'(i) < wr_n) mem_q[wr_idx + AW'(i)] <= wr_lj[31-8*i -: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         rsp_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         rsp_last_q  <= rsp_last_d;
         err_q       <= err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rdata     = rdata_q;
   assign rsp_last  = rsp_last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_data_ram_sync.sv
// Directed table-driven bench for data_ram_sync plus doubleword and reset sequences.
module tb_data_ram_sync;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        rw;
   logic [1:0]  mode;
   logic        signed_ld;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        rsp_last;
   logic        err;

   int checks = 0;
   int errors = 0;

   data_ram_sync #(.DEPTH(256), .ADDR_W(32), .SIGN_EXT_EN(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .rw        (rw),
      .mode      (mode),
      .signed_ld (signed_ld),
      .addr      (addr),
      .wdata     (wdata),
      .rsp_valid (rsp_valid),
      .rdata     (rdata),
      .rsp_last  (rsp_last),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rw;
      logic [1:0]  mode;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_rsp(input string nm, input logic v, input logic [31:0] d,
                          input logic last, input logic e);
      chk({nm, ".valid"}, 32'(rsp_valid), 32'(v));
      chk({nm, ".rdata"}, rdata, d);
      chk({nm, ".last"},  32'(rsp_last), 32'(last));
      chk({nm, ".err"},   32'(err), 32'(e));
   endtask

   // Present one request for one rising edge, then sample the registered response.
   task automatic drive(input logic r, input logic [1:0] m, input logic s,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1;
      rw        = r;
      mode      = m;
      signed_ld = s;
      addr      = a;
      wdata     = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{"wr_w10",     1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{"rd_w10",     1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{"rd_b11",     1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h000000AD, 1'b0};
      vecs[3]  = '{"wr_h20",     1'b1, 2'd1, 1'b0, 32'h20, 32'h000080F0, 32'h0,        1'b0};
      vecs[4]  = '{"rd_h20_s",   1'b0, 2'd1, 1'b1, 32'h20, 32'h0,        32'hFFFF80F0, 1'b0};
      vecs[5]  = '{"rd_h20_u",   1'b0, 2'd1, 1'b0, 32'h20, 32'h0,        32'h000080F0, 1'b0};
      vecs[6]  = '{"rd_b21_s",   1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        32'hFFFFFFF0, 1'b0};
      vecs[7]  = '{"wr_b12",     1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFF77, 32'h0,        1'b0};
      vecs[8]  = '{"rd_w10_b",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEAD77EF, 1'b0};
      vecs[9]  = '{"wr_w04",     1'b1, 2'd2, 1'b0, 32'h04, 32'h01020304, 32'h0,        1'b0};
      vecs[10] = '{"rd_w02_mis", 1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{"wr_h05_mis", 1'b1, 2'd1, 1'b0, 32'h05, 32'h0000FFFF, 32'h0,        1'b1};
      vecs[12] = '{"wr_d04_mis", 1'b1, 2'd3, 1'b0, 32'h04, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[13] = '{"rd_w04_kept",1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h01020304, 1'b0};
      vecs[14] = '{"wr_w252",    1'b1, 2'd2, 1'b0, 32'd252,32'hCAFEF00D, 32'h0,        1'b0};
      vecs[15] = '{"rd_w252",    1'b0, 2'd2, 1'b0, 32'd252,32'h0,        32'hCAFEF00D, 1'b0};
      vecs[16] = '{"rd_w256_rng",1'b0, 2'd2, 1'b0, 32'd256,32'h0,        32'h0,        1'b1};
      vecs[17] = '{"rd_d256_rng",1'b0, 2'd3, 1'b0, 32'd256,32'h0,        32'h0,        1'b1};

      reset = 1'b1; req_valid = 1'b0; rw = 1'b0; mode = 2'd0;
      signed_ld = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_rsp("reset", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("reset.ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rw, vecs[i].mode, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
         chk_rsp(vecs[i].name, 1'b1, vecs[i].exp_rdata, 1'b1, vecs[i].exp_err);
      end

      // Near the top of the address space the range sum must not wrap.
      drive(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0);
      chk_rsp("rd_wtop_rng", 1'b1, 32'h0, 1'b1, 1'b1);

      // Doubleword write with a 3-cycle gap before the low-word beat.
      drive(1'b1, 2'd3, 1'b0, 32'h40, 32'h11223344);
      chk_rsp("dwr_b1", 1'b1, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("dwr_gap.valid", 32'(rsp_valid), 32'd0);
         chk("dwr_gap.ready", 32'(req_ready), 32'd1);
      end
      drive(1'b0, 2'd0, 1'b0, 32'h99, 32'h55667788);
      chk_rsp("dwr_b2", 1'b1, 32'h0, 1'b1, 1'b0);

      // Doubleword read; address changes while the second beat is pending.
      drive(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
      chk_rsp("drd_b1", 1'b1, 32'h11223344, 1'b0, 1'b0);
      chk("drd_b1.ready", 32'(req_ready), 32'd0);
      addr = 32'h10;
      @(posedge clk);
      #1;
      chk_rsp("drd_b2", 1'b1, 32'h55667788, 1'b1, 1'b0);
      chk("drd_b2.ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("drd_done.valid", 32'(rsp_valid), 32'd0);

      // Reset while waiting for the low-word beat of a doubleword write.
      drive(1'b1, 2'd2, 1'b0, 32'h84, 32'h5A5A5A5A);
      chk_rsp("wr_w84", 1'b1, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 2'd3, 1'b0, 32'h80, 32'hAAAAAAAA);
      chk_rsp("dwr80_b1", 1'b1, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1; req_valid = 1'b1; rw = 1'b1; mode = 2'd3; wdata = 32'hBBBBBBBB;
      @(posedge clk);
      #1;
      chk_rsp("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("rst_mid.ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0; req_valid = 1'b0;
      drive(1'b0, 2'd2, 1'b0, 32'h84, 32'h0);
      chk_rsp("rd_w84_after", 1'b1, 32'h5A5A5A5A, 1'b1, 1'b0);
      drive(1'b0, 2'd3, 1'b0, 32'h80, 32'h0);
      chk_rsp("drd80_b1", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_rsp("drd80_b2", 1'b1, 32'h5A5A5A5A, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
